// File: rtl/sd_dat_block_tx_if.sv
// rtl/sd_dat_block_tx_if.sv - host byte stream, control/result and DAT0 pad signals of sd_dat_block_tx
interface sd_dat_block_tx_if;
    logic       bit_en;
    logic       start;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dat_in;
    logic       dat_out;
    logic       dat_oe;
    logic       busy;
    logic       done;
    logic [2:0] status;

    modport master (
        output bit_en, start, din, din_valid, dat_in,
        input  din_ready, dat_out, dat_oe, busy, done, status
    );

    modport slave (
        input  bit_en, start, din, din_valid, dat_in,
        output din_ready, dat_out, dat_oe, busy, done, status
    );
endinterface

// File: rtl/sd_dat_block_tx.sv
// rtl/sd_dat_block_tx.sv - SD DAT0 single-block write transmitter: frame + CRC16 out, CRC token and busy in
module sd_dat_block_tx #(
    parameter int BLOCK_BYTES = 512,
    parameter int TOKEN_WAIT  = 64,
    parameter int BUSY_WAIT   = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    sd_dat_block_tx_if.slave  bus
);
    localparam int BW  = $clog2(BLOCK_BYTES + 1);
    localparam int TW  = $clog2(TOKEN_WAIT + 1);
    localparam int UW  = $clog2(BUSY_WAIT + 1);
    localparam int TUW = (TW > UW) ? TW : UW;
    localparam int CW  = (TUW > 5) ? TUW : 5;

    localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
    localparam logic [CW-1:0] TOK_LAST  = CW'(TOKEN_WAIT - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SB, S_DATA, S_CRC, S_EB, S_TURN,
        S_TOK_WAIT, S_TOK, S_BUSYW, S_ABORT, S_FIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] byte_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [15:0]   crc;
    logic [CW-1:0] cnt;
    logic [2:0]    tok_bits;
    logic [2:0]    status_q;
    logic          dat_out_q;
    logic          dat_oe_q;
    logic          byte_last;
    logic          take_byte;
    logic          crc_inv;

    assign byte_last = (bit_idx == 3'd0);
    // A new byte is requested at the start bit and with bit 0 of every byte but the last.
    assign take_byte = (state == S_SB) ||
                       ((state == S_DATA) && byte_last && (byte_cnt != LAST_BYTE));
    assign crc_inv   = shreg[7] ^ crc[15];

    assign bus.din_ready = bus.bit_en && take_byte;
    assign bus.dat_out   = dat_out_q;
    assign bus.dat_oe    = dat_oe_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_FIN);
    assign bus.status    = status_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_PRE;
            S_FIN:  state_nxt = S_IDLE;
            default: begin
                if (bus.bit_en) begin
                    case (state)
                        S_PRE:  state_nxt = S_SB;
                        S_SB:   state_nxt = bus.din_valid ? S_DATA : S_ABORT;
                        S_DATA: begin
                            if (byte_last) begin
                                if (byte_cnt == LAST_BYTE) state_nxt = S_CRC;
                                else if (!bus.din_valid)   state_nxt = S_ABORT;
                            end
                        end
                        S_CRC:  if (cnt == CW'(15)) state_nxt = S_EB;
                        S_EB:   state_nxt = S_TURN;
                        S_TURN: if (cnt == CW'(1)) state_nxt = S_TOK_WAIT;
                        S_TOK_WAIT: begin
                            if (!bus.dat_in)           state_nxt = S_TOK;
                            else if (cnt == TOK_LAST)  state_nxt = S_FIN;
                        end
                        S_TOK:   if (cnt == CW'(3)) state_nxt = S_BUSYW;
                        S_BUSYW: if (bus.dat_in || (cnt == BUSY_LAST)) state_nxt = S_FIN;
                        S_ABORT: state_nxt = S_FIN;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_cnt  <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            crc       <= 16'h0000;
            cnt       <= '0;
            tok_bits  <= 3'b000;
            status_q  <= 3'b000;
            dat_out_q <= 1'b1;
            dat_oe_q  <= 1'b0;
        end else begin
            // cnt restarts on every state change and counts bit periods within a state.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (bus.bit_en && (state != S_IDLE)) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        crc      <= 16'h0000;
                        byte_cnt <= '0;
                    end
                end
                S_PRE: begin
                    if (bus.bit_en) begin
                        dat_out_q <= 1'b1;
                        dat_oe_q  <= 1'b1;
                    end
                end
                S_SB: begin
                    if (bus.bit_en) begin
                        dat_out_q <= 1'b0;
                        if (bus.din_valid) begin
                            shreg   <= bus.din;
                            bit_idx <= 3'd7;
                        end else begin
                            status_q <= 3'b000;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.bit_en) begin
                        dat_out_q <= shreg[7];
                        crc       <= {crc[14:12], crc[11] ^ crc_inv, crc[10:5],
                                      crc[4] ^ crc_inv, crc[3:0], crc_inv};
                        shreg     <= {shreg[6:0], 1'b0};
                        bit_idx   <= bit_idx - 3'd1;
                        if (byte_last && (byte_cnt != LAST_BYTE)) begin
                            if (bus.din_valid) begin
                                shreg    <= bus.din;
                                bit_idx  <= 3'd7;
                                byte_cnt <= byte_cnt + 1'b1;
                            end else begin
                                status_q <= 3'b000;
                            end
                        end
                    end
                end
                S_CRC: begin
                    // CRC register stays frozen; cnt walks it from bit 15 down.
                    if (bus.bit_en) dat_out_q <= crc[4'd15 - cnt[3:0]];
                end
                S_EB: begin
                    if (bus.bit_en) dat_out_q <= 1'b1;
                end
                S_TURN: begin
                    if (bus.bit_en) begin
                        dat_out_q <= 1'b1;
                        dat_oe_q  <= 1'b0;
                    end
                end
                S_TOK_WAIT: begin
                    if (bus.bit_en && bus.dat_in && (cnt == TOK_LAST)) status_q <= 3'b111;
                end
                S_TOK: begin
                    if (bus.bit_en) begin
                        if (cnt < CW'(3)) tok_bits <= {tok_bits[1:0], bus.dat_in};
                        if (cnt == CW'(3)) status_q <= bus.dat_in ? tok_bits : 3'b011;
                    end
                end
                S_BUSYW: begin
                    if (bus.bit_en && !bus.dat_in && (cnt == BUSY_LAST)) status_q <= 3'b100;
                end
                S_ABORT: begin
                    if (bus.bit_en) begin
                        dat_out_q <= 1'b1;
                        dat_oe_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dat_block_tx.sv
// tb/tb_sd_dat_block_tx.sv - directed bench for sd_dat_block_tx
module tb_sd_dat_block_tx;
    logic       clk       = 1'b0;
    logic       resetn    = 1'b1;
    logic       bit_en    = 1'b0;
    logic       start     = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
    logic       dat_in    = 1'b1;
    logic       sel       = 1'b0;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int d0       = 0;

    logic       line_q [$];
    logic [7:0] pat [0:511];

    sd_dat_block_tx_if if_big ();
    sd_dat_block_tx_if if_small ();

    assign if_big.bit_en      = bit_en;
    assign if_big.start       = start & ~sel;
    assign if_big.din         = din;
    assign if_big.din_valid   = din_valid;
    assign if_big.dat_in      = dat_in;
    assign if_small.bit_en    = bit_en;
    assign if_small.start     = start & sel;
    assign if_small.din       = din;
    assign if_small.din_valid = din_valid;
    assign if_small.dat_in    = dat_in;

    sd_dat_block_tx #(.BLOCK_BYTES(512), .TOKEN_WAIT(64), .BUSY_WAIT(65535)) u_big (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if_big)
    );

    sd_dat_block_tx #(.BLOCK_BYTES(4), .TOKEN_WAIT(64), .BUSY_WAIT(16)) u_small (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if_small)
    );

    logic       o_out, o_oe, o_ready, o_busy, o_done;
    logic [2:0] o_status;
    assign o_out    = sel ? if_small.dat_out   : if_big.dat_out;
    assign o_oe     = sel ? if_small.dat_oe    : if_big.dat_oe;
    assign o_ready  = sel ? if_small.din_ready : if_big.din_ready;
    assign o_busy   = sel ? if_small.busy      : if_big.busy;
    assign o_done   = sel ? if_small.done      : if_big.done;
    assign o_status = sel ? if_small.status    : if_big.status;

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            bit_en = ~bit_en;
        end
    end

    always @(negedge clk) if (o_done === 1'b1) done_cnt++;

    always @(posedge clk) begin
        if (bit_en) begin
            #1;
            if (o_oe === 1'b1) line_q.push_back(o_out);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_bound(input string tag, input int waited);
        checks++;
        failures++;
        $error("FAIL %s observed=wait_expired_after_%0d expected=event_within_bound", tag, waited);
    endtask

    task automatic strobe();
        do @(posedge clk); while (bit_en !== 1'b1);
        #1;
    endtask

    function automatic logic [15:0] crc16_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = pat[i][b] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic host(input int n_avail);
        int w;
        for (int i = 0; i < n_avail; i++) begin
            din       = pat[i];
            din_valid = 1'b1;
            w = 0;
            forever begin
                @(negedge clk);
                #1;
                if (o_ready === 1'b1 || w > 200) break;
                w++;
            end
            if (w > 200) begin
                fail_bound("host_ready", w);
                break;
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic run_tx(input int n_avail);
        line_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        host(n_avail);
    endtask

    task automatic wait_oe_low(input string tag);
        int n = 0;
        while (o_oe === 1'b1 && n < 6000) begin
            strobe();
            n++;
        end
        if (o_oe === 1'b1) fail_bound(tag, n);
    endtask

    task automatic card(input logic [2:0] tok, input logic endb, input int busy_len);
        wait_oe_low("card_oe");
        dat_in = 1'b0;
        strobe();
        strobe();
        for (int k = 2; k >= 0; k--) begin
            dat_in = tok[k];
            strobe();
        end
        dat_in = endb;
        strobe();
        for (int k = 0; k < busy_len; k++) begin
            dat_in = 1'b0;
            strobe();
        end
        dat_in = 1'b1;
        strobe();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) fail_bound(tag, n);
        repeat (6) @(posedge clk);
        chk({tag, "_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic check_frame(input string tag, input int nbytes, input logic [15:0] exp_crc);
        int          errs;
        int          base;
        logic [15:0] crc_obs;
        chk({tag, "_len"}, line_q.size(), 2 + 8 * nbytes + 17);
        if (line_q.size() == 2 + 8 * nbytes + 17) begin
            errs = 0;
            if (line_q[0] !== 1'b1) errs++;
            if (line_q[1] !== 1'b0) errs++;
            for (int i = 0; i < nbytes; i++)
                for (int k = 0; k < 8; k++)
                    if (line_q[2 + 8 * i + k] !== pat[i][7 - k]) errs++;
            chk({tag, "_bits"}, errs, 0);
            base    = 2 + 8 * nbytes;
            crc_obs = 16'h0000;
            for (int k = 0; k < 16; k++) crc_obs = {crc_obs[14:0], line_q[base + k]};
            chk({tag, "_crc"}, crc_obs, exp_crc);
            chk({tag, "_endbit"}, line_q[base + 16], 1);
        end
    endtask

    initial begin
        int n;
        // reset state, both instances
        #1 resetn = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_oe", o_oe, 0);
            chk("rst_out", o_out, 1);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_status", o_status, 3'b000);
            chk("rst_ready", o_ready, 0);
        end
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        sel = 1'b0;

        // T1: 512 x 0xFF, token 010, 8 busy bits
        for (int i = 0; i < 512; i++) pat[i] = 8'hFF;
        run_tx(512);
        card(3'b010, 1'b1, 8);
        wait_done("t1_done");
        check_frame("t1", 512, 16'h7FA1);
        chk("t1_status", o_status, 3'b010);
        chk("t1_idle", o_busy, 0);

        // T2: 4 zero bytes on the small instance
        sel = 1'b1;
        for (int i = 0; i < 4; i++) pat[i] = 8'h00;
        run_tx(4);
        card(3'b010, 1'b1, 2);
        wait_done("t2_done");
        check_frame("t2", 4, 16'h0000);
        chk("t2_status", o_status, 3'b010);

        // T3: underrun before byte 2
        pat[0] = 8'h11;
        pat[1] = 8'h22;
        run_tx(2);
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (o_ready === 1'b1 || n > 200) break;
            n++;
        end
        if (n > 200) fail_bound("t3_underrun", n);
        strobe();
        n = 0;
        while (o_oe === 1'b1 && n < 5) begin
            strobe();
            n++;
        end
        chk("t3_oe_within2", (n <= 2), 1);
        wait_done("t3_done");
        chk("t3_status", o_status, 3'b000);
        chk("t3_oe", o_oe, 0);

        // T4: no token from the card
        pat[0] = 8'h5A; pat[1] = 8'hC3; pat[2] = 8'h81; pat[3] = 8'h7E;
        run_tx(4);
        wait_oe_low("t4_oe");
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            strobe();
            #5;
            n++;
        end
        chk("t4_periods", n, 65);
        chk("t4_status", o_status, 3'b111);
        check_frame("t4", 4, crc16_model(4));

        // T5: CRC error token, bad token end bit, busy timeout
        pat[0] = 8'hDE; pat[1] = 8'hAD; pat[2] = 8'hBE; pat[3] = 8'hEF;
        run_tx(4);
        card(3'b101, 1'b1, 4);
        wait_done("t5a_done");
        chk("t5a_status", o_status, 3'b101);
        check_frame("t5a", 4, crc16_model(4));

        run_tx(4);
        card(3'b010, 1'b0, 2);
        wait_done("t5b_done");
        chk("t5b_status", o_status, 3'b011);

        run_tx(4);
        card(3'b010, 1'b1, 20);
        wait_done("t5c_done");
        chk("t5c_status", o_status, 3'b100);

        // T6: async reset mid-DATA, then a clean block
        pat[0] = 8'h01; pat[1] = 8'h80;
        run_tx(2);
        strobe();
        strobe();
        strobe();
        chk("t6_pre_oe", o_oe, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_oe", o_oe, 0);
        chk("t6_rst_out", o_out, 1);
        chk("t6_rst_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        chk("t6_rst_status", o_status, 3'b000);
        pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h0F; pat[3] = 8'hF0;
        run_tx(4);
        card(3'b010, 1'b1, 3);
        wait_done("t6_done");
        check_frame("t6", 4, crc16_model(4));
        chk("t6_status", o_status, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
